// File: rtl/soc_system_pll_pkg.sv
// soc_system_pll_pkg: state codes and default timing for the system PLL reset sequencer
package soc_system_pll_pkg;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } pll_state_e;

    localparam int DEF_RST_CYCLES    = 16;
    localparam int DEF_LOCK_TIMEOUT  = 50000;
    localparam int DEF_STABLE_CYCLES = 1024;
    localparam int DEF_MAX_RETRIES   = 3;
    localparam int DEF_LOST_W        = 8;

endpackage

// File: rtl/soc_system_sync_2ff.sv
// soc_system_sync_2ff: two-flop synchronizer for an asynchronous status bit, clears to 0 on reset
module soc_system_sync_2ff (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [1:0] sync_q;
    logic [1:0] sync_d;

    // shift the async bit through two stages
    always_comb sync_d = {sync_q[0], d};

    // synchronizer register with synchronous active-low clear
    always_ff @(posedge clk) begin
        if (!reset_n) sync_q <= '0;
        else          sync_q <= sync_d;
    end

    assign q = sync_q[1];

endmodule

// File: rtl/soc_system_pll_reset_sequencer.sv
// soc_system_pll_reset_sequencer: pulses PLL reset, qualifies lock, releases fabric reset, retries and faults
module soc_system_pll_reset_sequencer
    import soc_system_pll_pkg::*;
#(
    parameter int RST_CYCLES    = DEF_RST_CYCLES,
    parameter int LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int MAX_RETRIES   = DEF_MAX_RETRIES,
    parameter int LOST_W        = DEF_LOST_W
) (
    input  logic                               clk,
    input  logic                               reset_n,
    input  logic                               pll_locked_async,
    input  logic                               restart,
    output logic                               pll_rst,
    output logic                               sys_reset_n,
    output logic                               fault,
    output logic [2:0]                         state,
    output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt,
    output logic [LOST_W-1:0]                  lost_cnt
);

    localparam int RW  = $clog2(RST_CYCLES + 1);
    localparam int TW  = $clog2(LOCK_TIMEOUT + 1);
    localparam int SW  = $clog2(STABLE_CYCLES + 1);
    localparam int RTW = $clog2(MAX_RETRIES + 1);

    if (LOCK_TIMEOUT <= STABLE_CYCLES + 2) begin : g_bad_timeout
        $error("LOCK_TIMEOUT must exceed STABLE_CYCLES+2");
    end

    pll_state_e        state_q, state_d;
    logic [RW-1:0]     rst_cnt_q, rst_cnt_d;
    logic [TW-1:0]     tmo_cnt_q, tmo_cnt_d;
    logic [SW-1:0]     stab_cnt_q, stab_cnt_d;
    logic [RTW-1:0]    retry_cnt_q, retry_cnt_d;
    logic [LOST_W-1:0] lost_cnt_q, lost_cnt_d;
    logic              pll_rst_q, pll_rst_d;
    logic              sys_reset_n_q, sys_reset_n_d;
    logic              fault_q, fault_d;
    logic              locked_s;
    logic              waiting;

    soc_system_sync_2ff u_lock_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (pll_locked_async),
        .q       (locked_s)
    );

    // next state, counters and registered outputs; restart overrides every other transition
    always_comb begin
        state_d     = state_q;
        retry_cnt_d = retry_cnt_q;
        lost_cnt_d  = lost_cnt_q;
        waiting     = (state_q == WAIT_LOCK) || (state_q == STABLE);
        case (state_q)
            PLL_RST:   if (rst_cnt_q == RW'(RST_CYCLES - 1)) state_d = WAIT_LOCK;
            WAIT_LOCK: if (locked_s) state_d = STABLE;
            STABLE: begin
                if (!locked_s) state_d = WAIT_LOCK;
                else if (stab_cnt_q == SW'(STABLE_CYCLES - 1)) state_d = RUN;
            end
            RUN: begin
                if (!locked_s) begin
                    state_d    = PLL_RST;
                    lost_cnt_d = (&lost_cnt_q) ? lost_cnt_q : lost_cnt_q + 1'b1;
                end
            end
            FAULT:   state_d = FAULT;
            default: state_d = PLL_RST;
        endcase
        if (waiting && tmo_cnt_q == TW'(LOCK_TIMEOUT - 1)) begin
            state_d     = (retry_cnt_q == RTW'(MAX_RETRIES)) ? FAULT : PLL_RST;
            retry_cnt_d = (retry_cnt_q == RTW'(MAX_RETRIES)) ? retry_cnt_q : retry_cnt_q + 1'b1;
        end
        if (state_d == RUN) retry_cnt_d = '0;
        if (restart) begin
            state_d     = PLL_RST;
            retry_cnt_d = '0;
            lost_cnt_d  = lost_cnt_q;
        end
        rst_cnt_d     = (state_q == PLL_RST && state_d == PLL_RST && !restart) ? rst_cnt_q + 1'b1 : '0;
        tmo_cnt_d     = (state_d == PLL_RST) ? '0 : waiting ? tmo_cnt_q + 1'b1 : tmo_cnt_q;
        stab_cnt_d    = (state_q == STABLE && state_d == STABLE) ? stab_cnt_q + 1'b1 : '0;
        pll_rst_d     = (state_d == PLL_RST) || (state_d == FAULT);
        sys_reset_n_d = (state_d == RUN);
        fault_d       = (state_d == FAULT);
    end

    // state, counter and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= PLL_RST;
            rst_cnt_q     <= '0;
            tmo_cnt_q     <= '0;
            stab_cnt_q    <= '0;
            retry_cnt_q   <= '0;
            lost_cnt_q    <= '0;
            pll_rst_q     <= 1'b1;
            sys_reset_n_q <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            state_q       <= state_d;
            rst_cnt_q     <= rst_cnt_d;
            tmo_cnt_q     <= tmo_cnt_d;
            stab_cnt_q    <= stab_cnt_d;
            retry_cnt_q   <= retry_cnt_d;
            lost_cnt_q    <= lost_cnt_d;
            pll_rst_q     <= pll_rst_d;
            sys_reset_n_q <= sys_reset_n_d;
            fault_q       <= fault_d;
        end
    end

    assign pll_rst     = pll_rst_q;
    assign sys_reset_n = sys_reset_n_q;
    assign fault       = fault_q;
    assign state       = state_q;
    assign retry_cnt   = retry_cnt_q;
    assign lost_cnt    = lost_cnt_q;

endmodule

// File: tb/tb_soc_system_pll_reset_sequencer.sv
// tb_soc_system_pll_reset_sequencer: directed scenario bench for the PLL reset sequencer
`timescale 1ns/1ps
module tb_soc_system_pll_reset_sequencer;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       lock = 1'b0;
    logic       restart = 1'b0;
    logic       pll_rst, sys_reset_n, fault;
    logic [2:0] state;
    logic [1:0] retry_cnt;
    logic [7:0] lost_cnt;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    soc_system_pll_reset_sequencer #(
        .RST_CYCLES    (4),
        .LOCK_TIMEOUT  (20),
        .STABLE_CYCLES (8),
        .MAX_RETRIES   (2),
        .LOST_W        (8)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .pll_locked_async (lock),
        .restart          (restart),
        .pll_rst          (pll_rst),
        .sys_reset_n      (sys_reset_n),
        .fault            (fault),
        .state            (state),
        .retry_cnt        (retry_cnt),
        .lost_cnt         (lost_cnt)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // after this task the current cycle is "cycle 0": reset_n just went high
    task automatic apply_reset;
        reset_n = 1'b0;
        lock    = 1'b0;
        restart = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0;
        lock    = 1'b1;
        restart = 1'b0;
        repeat (3) tick();
        total++;
        if ({state, pll_rst, sys_reset_n, fault, retry_cnt, lost_cnt} !== {3'd0, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0}) begin
            bad++;
            $display("FAIL reset_values got st=%0d prst=%b srn=%b flt=%b rty=%0d lost=%0d exp 0 1 0 0 0 0",
                     state, pll_rst, sys_reset_n, fault, retry_cnt, lost_cnt);
        end
    endtask

    task automatic test_nominal;
        apply_reset();
        for (int c = 0; c <= 24; c++) begin
            lock = (c >= 9);
            total++;
            if (pll_rst !== (c < 4)) begin
                bad++;
                $display("FAIL nominal_pll_rst c=%0d got=%b exp=%b", c, pll_rst, c < 4);
            end
            total++;
            if (sys_reset_n !== (c >= 20)) begin
                bad++;
                $display("FAIL nominal_sys_reset_n c=%0d got=%b exp=%b", c, sys_reset_n, c >= 20);
            end
            if (c == 12) begin
                total++;
                if (state !== 3'd2) begin
                    bad++;
                    $display("FAIL nominal_stable c=%0d got=%0d exp=2", c, state);
                end
            end
            tick();
        end
    endtask

    task automatic test_no_lock;
        int hi, rises;
        logic prev;
        hi = 0;
        rises = 0;
        prev = 1'b0;
        apply_reset();
        for (int c = 0; c <= 79; c++) begin
            if (c < 72) begin
                hi += int'(pll_rst);
                if (pll_rst && !prev) rises++;
                prev = pll_rst;
            end
            if (c == 23) begin
                total++;
                if (state !== 3'd1) begin
                    bad++;
                    $display("FAIL nolock_wait c=%0d got=%0d exp=1", c, state);
                end
            end
            if (c == 24) begin
                total++;
                if ({state, retry_cnt} !== {3'd0, 2'd1}) begin
                    bad++;
                    $display("FAIL nolock_retry1 got st=%0d rty=%0d exp st=0 rty=1", state, retry_cnt);
                end
            end
            if (c == 72 || c == 79) begin
                total++;
                if ({state, fault, pll_rst, retry_cnt, sys_reset_n} !== {3'd4, 1'b1, 1'b1, 2'd2, 1'b0}) begin
                    bad++;
                    $display("FAIL nolock_fault c=%0d got st=%0d flt=%b prst=%b rty=%0d srn=%b exp 4 1 1 2 0",
                             c, state, fault, pll_rst, retry_cnt, sys_reset_n);
                end
            end
            tick();
        end
        total++;
        if (hi !== 12 || rises !== 3) begin
            bad++;
            $display("FAIL nolock_pulses got cycles=%0d pulses=%0d exp cycles=12 pulses=3", hi, rises);
        end
    endtask

    task automatic test_chatter_and_drop;
        apply_reset();
        for (int c = 0; c <= 60; c++) begin
            lock = (c >= 9) && (c != 15) && (c != 40);
            if (c == 17 || c == 19 || c == 23 || c == 36) begin
                total++;
                if (state !== 3'd2) begin
                    bad++;
                    $display("FAIL chatter_stable c=%0d got=%0d exp=2", c, state);
                end
            end
            if (c == 18) begin
                total++;
                if (state !== 3'd1) begin
                    bad++;
                    $display("FAIL chatter_back_to_wait got=%0d exp=1", state);
                end
            end
            if (c == 24) begin
                total++;
                if ({state, retry_cnt} !== {3'd0, 2'd1}) begin
                    bad++;
                    $display("FAIL chatter_timeout got st=%0d rty=%0d exp st=0 rty=1", state, retry_cnt);
                end
            end
            if (c == 37 || c == 42 || c == 56) begin
                total++;
                if ({state, sys_reset_n, retry_cnt} !== {3'd3, 1'b1, 2'd0}) begin
                    bad++;
                    $display("FAIL chatter_run c=%0d got st=%0d srn=%b rty=%0d exp 3 1 0",
                             c, state, sys_reset_n, retry_cnt);
                end
            end
            if (c == 43 || c == 46) begin
                total++;
                if ({state, sys_reset_n, pll_rst, lost_cnt} !== {3'd0, 1'b0, 1'b1, 8'd1}) begin
                    bad++;
                    $display("FAIL drop_resequence c=%0d got st=%0d srn=%b prst=%b lost=%0d exp 0 0 1 1",
                             c, state, sys_reset_n, pll_rst, lost_cnt);
                end
            end
            if (c == 47) begin
                total++;
                if ({state, pll_rst} !== {3'd1, 1'b0}) begin
                    bad++;
                    $display("FAIL drop_pulse_end got st=%0d prst=%b exp 1 0", state, pll_rst);
                end
            end
            tick();
        end
    endtask

    task automatic test_lost_saturate;
        for (int n = 1; n < 300; n++) begin
            for (int k = 0; k < 100 && state !== 3'd3; k++) tick();
            lock = 1'b0;
            tick();
            lock = 1'b1;
            for (int k = 0; k < 10 && sys_reset_n !== 1'b0; k++) tick();
            if (n == 99 || n == 254 || n == 299) begin
                total++;
                if (sys_reset_n !== 1'b0 || lost_cnt !== ((n == 99) ? 8'd100 : 8'd255)) begin
                    bad++;
                    $display("FAIL lost_count n=%0d got lost=%0d srn=%b exp lost=%0d srn=0",
                             n, lost_cnt, sys_reset_n, (n == 99) ? 100 : 255);
                end
            end
        end
    endtask

    task automatic test_reset_mid_stable;
        lock = 1'b1;
        for (int k = 0; k < 100 && state !== 3'd2; k++) tick();
        repeat (3) tick();
        total++;
        if (state !== 3'd2 || lost_cnt !== 8'd255) begin
            bad++;
            $display("FAIL midstable_setup got st=%0d lost=%0d exp st=2 lost=255", state, lost_cnt);
        end
        reset_n = 1'b0;
        tick();
        total++;
        if ({state, pll_rst, sys_reset_n, fault, retry_cnt, lost_cnt} !== {3'd0, 1'b1, 1'b0, 1'b0, 2'd0, 8'd0}) begin
            bad++;
            $display("FAIL midstable_reset got st=%0d prst=%b srn=%b flt=%b rty=%0d lost=%0d exp 0 1 0 0 0 0",
                     state, pll_rst, sys_reset_n, fault, retry_cnt, lost_cnt);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_fault_restart;
        apply_reset();
        repeat (75) tick();
        total++;
        if ({state, fault, pll_rst, retry_cnt, sys_reset_n} !== {3'd4, 1'b1, 1'b1, 2'd2, 1'b0}) begin
            bad++;
            $display("FAIL restart_setup got st=%0d flt=%b prst=%b rty=%0d srn=%b exp 4 1 1 2 0",
                     state, fault, pll_rst, retry_cnt, sys_reset_n);
        end
        restart = 1'b1;
        tick();
        restart = 1'b0;
        for (int r = 0; r <= 13; r++) begin
            lock = 1'b1;
            if (r == 0) begin
                total++;
                if ({state, fault, retry_cnt, pll_rst} !== {3'd0, 1'b0, 2'd0, 1'b1}) begin
                    bad++;
                    $display("FAIL restart_fault got st=%0d flt=%b rty=%0d prst=%b exp 0 0 0 1",
                             state, fault, retry_cnt, pll_rst);
                end
            end
            if (r == 4 || r == 12) begin
                total++;
                if (state !== ((r == 4) ? 3'd1 : 3'd2)) begin
                    bad++;
                    $display("FAIL restart_sequence r=%0d got=%0d exp=%0d", r, state, (r == 4) ? 1 : 2);
                end
            end
            if (r == 13) begin
                total++;
                if ({state, sys_reset_n} !== {3'd3, 1'b1}) begin
                    bad++;
                    $display("FAIL restart_run got st=%0d srn=%b exp 3 1", state, sys_reset_n);
                end
            end
            tick();
        end
    endtask

    task automatic test_restart_vs_loss;
        lock = 1'b0;
        tick();
        tick();
        restart = 1'b1;
        tick();
        restart = 1'b0;
        lock = 1'b1;
        total++;
        if ({state, lost_cnt, retry_cnt, sys_reset_n} !== {3'd0, 8'd0, 2'd0, 1'b0}) begin
            bad++;
            $display("FAIL restart_wins got st=%0d lost=%0d rty=%0d srn=%b exp 0 0 0 0",
                     state, lost_cnt, retry_cnt, sys_reset_n);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_no_lock();
        test_chatter_and_drop();
        test_lost_saturate();
        test_reset_mid_stable();
        test_fault_restart();
        test_restart_vs_loss();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

endmodule
